display_framebuffer: RTL and testbench
======================================

Name: display_framebuffer

Overview:
- Double-buffered pixel store that sits directly upstream of display_driver.
- The read port answers the driver's row/column fetch address with a 24-bit RGB pixel.
- The write port accepts a linear pixel stream from the host-side loader into the back bank.
- Bank swap is deferred to the driver's frame_complete pulse, so a frame is never displayed half-written.

Parameters:
- rows, 8, panel rows per segment; must match display_driver rows.
- columns, 32, panel columns; must match display_driver columns.
- pixelwidth, 24, bits per pixel (8 R, 8 G, 8 B).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- row  in  clog2(rows)  driver fetch row.
- column  in  clog2(columns)  driver fetch column.
- pixel  out  pixelwidth  registered pixel for (row, column) from the front bank.
- frame_complete  in  1  one-cycle pulse from display_driver at the end of each frame.
- wr_valid  in  1  write data valid.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_first  in  1  qualifies the current beat as pixel 0; the pointer restarts at 0.
- wr_data  in  pixelwidth  pixel being written.
- swap_req  in  1  one-cycle request to present the back bank at the next frame boundary.
- swap_pending  out  1  high from an accepted swap_req until the swap executes.
- front_bank  out  1  index of the bank currently being displayed.

Behaviour:
- Reset (rst=0, asynchronous):
  - pixel=0, front_bank=0, swap_pending=0, write pointer=0, wr_ready=1.
  - RAM contents are not cleared.
- Storage:
  - Two banks of rows*columns words.
  - Address = row*columns + column; the multiply is realised as concatenation when columns is a power of two.
- Read:
  - 1-cycle latency: the address presented at edge N yields pixel valid after edge N+1.
  - Reads always come from front_bank and are never stalled.
- Write:
  - Accepted beat: writes back bank (~front_bank) at the pointer, then pointer+1.
  - Pointer wraps from rows*columns-1 to 0.
  - If wr_first is set on an accepted beat, the beat is written at address 0 and the pointer becomes 1.
  - wr_ready = !swap_pending; beats are held off while a swap waits.
- Swap FSM, states IDLE and PENDING:
  - IDLE: swap_req -> PENDING, swap_pending=1.
  - PENDING: frame_complete -> toggle front_bank, pointer=0, back to IDLE, swap_pending=0.
  - swap_req while in PENDING is ignored, not queued.
  - swap_req and frame_complete in the same cycle while in IDLE: the swap executes immediately that edge and swap_pending stays 0.
  - frame_complete in IDLE: no effect.
- The pixel register follows the new front_bank from the first read issued after the toggle edge.
- A write beat and a swap on the same edge cannot occur, because wr_ready=0 in PENDING.
- Reset mid-frame or mid-stream abandons the pending swap and the pointer, and returns to bank 0.

Decomposition:
- Shared include display_params.vh holds: default rows/columns/pixelwidth, address-width localparams (row_w, col_w, addr_w = row_w+col_w+1 including the bank bit), and FSM state encodings.
- One sub-module, display_fb_ram:
  - Simple dual-port, depth 2*rows*columns.
  - Synchronous read, one write port.
  - Infers block RAM.

Test Plan:
- Reset release with row=0, column=0 -> pixel=0, front_bank=0, wr_ready=1, swap_pending=0.
- Write bank 1 fully:
  - Stream 256 beats with wr_data=index and wr_first on beat 0.
  - swap_req, then frame_complete 10 cycles later.
  - Expect front_bank=1 on the next cycle.
  - Fetch (3,5) -> pixel=24'd101 one cycle later.
- Deferral:
  - Assert swap_req, then hold wr_valid for 20 cycles.
  - Expect wr_ready=0 and no beats accepted until frame_complete.
  - front_bank toggles exactly on the frame_complete edge.
- Simultaneous swap_req and frame_complete in IDLE -> front_bank toggles at that edge and swap_pending is never seen high.
- Pointer wrap:
  - Write 257 beats without wr_first.
  - Expect beat 256 (value 24'hABCDEF) at address 0 of the back bank.
  - After a swap, fetch (0,0) -> 24'hABCDEF.
- Reset mid-PENDING:
  - Assert rst=0 for 1 cycle while swap_pending=1.
  - Expect swap_pending=0 and front_bank=0.
  - A following frame_complete causes no toggle.

Source files
------------

// File: rtl/display_framebuffer_pkg.sv
// Shared geometry defaults and swap-control encoding for the double-buffered
// display framebuffer.
package display_framebuffer_pkg;

  localparam int rows_default       = 8;
  localparam int columns_default    = 32;
  localparam int pixelwidth_default = 24;

  // Address widths for the default geometry; the extra bit selects the bank.
  localparam int default_row_w  = $clog2(rows_default);
  localparam int default_col_w  = $clog2(columns_default);
  localparam int default_addr_w = default_row_w + default_col_w + 1;

  typedef enum logic {
    st_idle    = 1'b0,
    st_pending = 1'b1
  } swap_state_e;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/display_fb_ram.sv
// Simple dual-port pixel store: one write port, one synchronous read port,
// shaped so synthesis maps it onto block RAM.
module display_fb_ram #(
  parameter int addr_w = 9,
  parameter int data_w = 24,
  parameter int depth  = 512
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [data_w-1:0] wr_data,
  input  logic [addr_w-1:0] rd_addr,
  output logic [data_w-1:0] rd_data
);

  logic [data_w-1:0] mem [depth];

  // NOTE: no reset on the array or the read register; a reset here would stop
  // block RAM inference, and the top masks the output until the first read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/display_framebuffer.sv
// Double-buffered framebuffer: the driver reads the front bank while the host
// loader fills the back bank; swaps wait for the driver's frame boundary.
module display_framebuffer
  import display_framebuffer_pkg::*;
#(
  parameter int rows       = rows_default,
  parameter int columns    = columns_default,
  parameter int pixelwidth = pixelwidth_default
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(rows)-1:0]    row,
  input  logic [$clog2(columns)-1:0] column,
  output logic [pixelwidth-1:0]      pixel,
  input  logic                       frame_complete,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       wr_first,
  input  logic [pixelwidth-1:0]      wr_data,
  input  logic                       swap_req,
  output logic                       swap_pending,
  output logic                       front_bank
);

  localparam int row_w      = $clog2(rows);
  localparam int col_w      = $clog2(columns);
  localparam int loc_w      = row_w + col_w;
  localparam int addr_w     = loc_w + 1;
  localparam int bank_words = rows * columns;
  localparam logic [loc_w-1:0] last_loc = loc_w'(bank_words - 1);

  swap_state_e       state, state_next;
  logic              do_swap;
  logic              wr_accept;
  logic              primed;
  logic [loc_w-1:0]  wr_ptr, ptr_next, wr_loc, rd_loc;
  logic [addr_w-1:0] rd_addr, wr_addr;
  logic [pixelwidth-1:0] rd_data;

  assign swap_pending = (state == st_pending);
  assign wr_ready     = (state == st_idle);
  assign wr_accept    = wr_valid && wr_ready;
  assign wr_loc       = wr_first ? '0 : wr_ptr;

  generate
    if (is_pow2(columns)) begin : g_loc_concat
      assign rd_loc = {row, column};
    end else begin : g_loc_mult
      assign rd_loc = loc_w'(row * columns + column);
    end

    if (is_pow2(bank_words)) begin : g_bank_concat
      assign rd_addr = {front_bank, rd_loc};
      assign wr_addr = {~front_bank, wr_loc};
    end else begin : g_bank_offset
      assign rd_addr = front_bank ? addr_w'(rd_loc) + addr_w'(bank_words) : addr_w'(rd_loc);
      assign wr_addr = front_bank ? addr_w'(wr_loc) : addr_w'(wr_loc) + addr_w'(bank_words);
    end
  endgenerate

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    do_swap    = 1'b0;
    unique case (state)
      st_idle: begin
        // A request landing on the frame boundary itself swaps at once.
        if (swap_req) begin
          if (frame_complete) do_swap = 1'b1;
          else                state_next = st_pending;
        end
      end
      st_pending: begin
        if (frame_complete) begin
          do_swap    = 1'b1;
          state_next = st_idle;
        end
      end
      default: state_next = st_idle;
    endcase

    ptr_next = wr_ptr;
    if (wr_accept) ptr_next = (wr_loc == last_loc) ? '0 : wr_loc + loc_w'(1);
    if (do_swap)   ptr_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= st_idle;
      front_bank <= 1'b0;
      wr_ptr     <= '0;
      primed     <= 1'b0;
    end else begin
      state  <= state_next;
      wr_ptr <= ptr_next;
      primed <= 1'b1;
      if (do_swap) front_bank <= ~front_bank;
    end
  end

  // The RAM read register is not resettable, so pixel reads zero until the
  // first read after reset has landed.
  assign pixel = primed ? rd_data : '0;

  display_fb_ram #(
    .addr_w (addr_w),
    .data_w (pixelwidth),
    .depth  (2 * bank_words)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_display_framebuffer.sv
// Scoreboard bench for display_framebuffer: stimulus pushes expected outputs
// from a bank-array reference model; a monitor pops and compares every cycle.
module tb_display_framebuffer;

  localparam int rows    = 8;
  localparam int columns = 32;
  localparam int words   = rows * columns;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  row = '0;
  logic [4:0]  column = '0;
  logic [23:0] pixel;
  logic        frame_complete = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        wr_first = 1'b0;
  logic [23:0] wr_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_pending;
  logic        front_bank;

  display_framebuffer dut (
    .clk            (clk),
    .rst            (rst),
    .row            (row),
    .column         (column),
    .pixel          (pixel),
    .frame_complete (frame_complete),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_first       (wr_first),
    .wr_data        (wr_data),
    .swap_req       (swap_req),
    .swap_pending   (swap_pending),
    .front_bank     (front_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          known;
    logic [23:0] pix;
    bit          front;
    bit          pend;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] ref_mem   [2][words];
  bit          ref_known [2][words];
  bit          ref_front = 1'b0;
  bit          ref_pend  = 1'b0;
  int          ref_ptr   = 0;
  int          ref_acc   = 0;
  int          dut_acc   = 0;
  int          total     = 0;
  int          bad       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one clock's worth of inputs and record what the following edge must produce.
  task automatic cycle(input bit r_n, input int r, input int c, input bit v, input bit first,
                       input logic [23:0] d, input bit sreq, input bit fc);
    exp_t e;
    int   a;
    int   back;
    @(negedge clk);
    #1;
    rst            = r_n;
    row            = 3'(r);
    column         = 5'(c);
    wr_valid       = v;
    wr_first       = first;
    wr_data        = d;
    swap_req       = sreq;
    frame_complete = fc;
    if (r_n && wr_valid && wr_ready) dut_acc++;

    if (!r_n) begin
      ref_front = 1'b0;
      ref_pend  = 1'b0;
      ref_ptr   = 0;
      e.known   = 1'b1;
      e.pix     = '0;
    end else begin
      a       = r * columns + c;
      e.known = ref_known[ref_front][a];
      e.pix   = ref_mem[ref_front][a];
      back    = ref_front ? 0 : 1;
      if (v && !ref_pend) begin
        a = first ? 0 : ref_ptr;
        ref_mem[back][a]   = d;
        ref_known[back][a] = 1'b1;
        ref_ptr = (a + 1) % words;
        ref_acc++;
      end
      if (fc && (ref_pend || sreq)) begin
        ref_front = !ref_front;
        ref_pend  = 1'b0;
        ref_ptr   = 0;
      end else if (sreq) begin
        ref_pend = 1'b1;
      end
    end
    e.front = ref_front;
    e.pend  = ref_pend;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.known) check("pixel", pixel, e.pix);
        check("front_bank", front_bank, e.front);
        check("swap_pending", swap_pending, e.pend);
        check("wr_ready", wr_ready, !e.pend);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stimulus
    int acc0;

    // Reset and release with fetch address (0,0).
    for (int i = 0; i < 2; i++) cycle(1'b0, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("rst_pixel", pixel, 0);
    check("rst_front_bank", front_bank, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_swap_pending", swap_pending, 0);

    // Fill bank 1 with its own indices, then swap on a frame boundary.
    for (int i = 0; i < words; i++)
      cycle(1'b1, i % rows, i % columns, 1'b1, i == 0, 24'(i), 1'b0, 1'b0);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(9);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(1);
    check("swap_front_bank", front_bank, 1);
    cycle(1'b1, 3, 5, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(1);
    check("fetch_3_5", pixel, 24'd101);

    // Deferral: writes are held off while the swap waits.
    acc0 = dut_acc;
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 1, 2, 1'b1, 1'b0, 24'($urandom), 1'b0, 1'b0);
    check("defer_wr_ready", wr_ready, 0);
    cycle(1'b1, 1, 2, 1'b1, 1'b0, 24'h123456, 1'b0, 1'b1);
    check("defer_front_before_edge", front_bank, 1);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("defer_front_after_edge", front_bank, 0);
    check("defer_beats_accepted", 32'(dut_acc - acc0), 0);

    // Simultaneous request and frame boundary while idle.
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(1);
    check("simul_front_bank", front_bank, 1);
    check("simul_swap_pending", swap_pending, 0);

    // Pointer wrap: beat 256 lands on address 0 of the back bank.
    for (int i = 0; i <= words; i++)
      cycle(1'b1, 0, 0, 1'b1, 1'b0, (i == words) ? 24'hABCDEF : 24'(i), 1'b0, 1'b0);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 0, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("wrap_0_0", pixel, 24'hABCDEF);
    idle(1);
    check("wrap_0_1", pixel, 24'd1);

    // Reset while a swap is pending.
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check("pre_reset_pending", swap_pending, 1);
    check("pre_reset_front", front_bank, 1);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("post_reset_pending", swap_pending, 0);
    check("post_reset_front", front_bank, 0);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(1);
    check("post_reset_fc_no_toggle", front_bank, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++)
      cycle(1'b1, $urandom_range(0, rows - 1), $urandom_range(0, columns - 1),
            1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0, 24'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);

    idle(3);
    @(negedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("accepted_beats", 32'(dut_acc), 32'(ref_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
